alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits (32 or 64).
REQ-002 Parameter ROB_WIDTH, default 4, width of the reorder-buffer tag carried with each op.
REQ-003 Parameter DEPTH, default 2, pipeline stages from accept to result (legal 1..4).
REQ-004 clk_in  input  1  clock, all state updates on rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-low.
REQ-006 rdy_in  input  1  global enable; low freezes all state.
REQ-007 clear  input  1  flush; kills every op accepted or in flight.
REQ-008 in_valid  input  1  op request present.
REQ-009 in_ready  output  1  block accepts op this cycle.
REQ-010 alu_op  input  5  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 BEQ, 11 BGE, 12 BGEU, 13 BNE, 14 ADD_PC, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU.
REQ-011 a, b  input  XLEN each  operands.
REQ-012 in_tag  input  ROB_WIDTH  tag of incoming op.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer takes result this cycle.
REQ-015 result  output  XLEN  computed value.
REQ-016 out_tag  output  ROB_WIDTH  tag of op producing result.

Function
REQ-017 Accept occurs when in_valid && in_ready && rdy_in && !clear; op, operands and tag captured in stage 0.
REQ-018 Each stage holds valid bit, tag and partial result; stage k advances when stage k+1 is empty or advancing; last stage advances when out_ready.
REQ-019 in_ready = rdy_in && !clear && (stage 0 empty or stage 0 advancing); full throughput of one op per cycle with out_ready held high.
REQ-020 Latency: result and tag appear on out_valid exactly DEPTH cycles after accept absent backpressure; ops retire in accept order.
REQ-021 With out_valid high and out_ready low, result, out_tag, out_valid hold stable until handshake.
REQ-022 Arithmetic modulo 2^XLEN; shift amount b[log2(XLEN)-1:0]; SRA arithmetic (sign-filled).
REQ-023 SLT, BGE compare signed; SLTU, BGEU unsigned; SLT/SLTU/BEQ/BGE/BGEU/BNE yield 1 or 0 zero-extended.
REQ-024 ADD_PC yields a + b - 4.
REQ-025 Undefined opcodes (15, 20-31) complete normally with result 0.
REQ-026 clear high with rdy_in high: all stage valid bits zero next cycle, concurrent in_valid dropped, out_valid low next cycle; clear takes priority over accept and output handshake.
REQ-027 rdy_in low: no state changes, in_ready low, outputs hold; clear ignored while rdy_in low.

Reset
REQ-028 rst_in low asynchronously clears all stage valid bits; out_valid 0, result 0, out_tag 0, in_ready 0 while asserted.
REQ-029 Reset mid-operation discards all in-flight ops; first accept possible on first rising edge after rst_in deasserts.

Configuration
REQ-030 Macro ALU_PIPE_MUL_EN defined: opcodes 16-19 compute low XLEN bits (MUL) or high XLEN bits of signed x signed (MULH), signed x unsigned (MULHSU), unsigned x unsigned (MULHU) product, same DEPTH latency.
REQ-031 Macro ALU_PIPE_MUL_EN undefined: no multiplier instantiated; opcodes 16-19 treated as undefined per REQ-025.

Verification
REQ-032 Defaults, out_ready=1, accept ADD a=5 b=7 tag=3 -> out_valid with result 12, out_tag 3, exactly 2 cycles later.
REQ-033 Back-to-back SRA a=0x80000000 b=4, SLT a=0xFFFFFFFF b=1, SLTU same operands, ADD_PC a=0x100 b=8 -> results 0xF8000000, 1, 0, 0x104 on consecutive cycles in order.
REQ-034 out_ready low 5 cycles with 3 ops issued -> in_ready drops once pipeline full, output stable, all 3 results delivered in order after out_ready rises, none lost or duplicated.
REQ-035 clear asserted with 2 ops in flight plus in_valid high -> out_valid 0 next cycle, no flushed tag ever appears.
REQ-036 rst_in pulsed low mid-stream -> outputs 0 immediately without clock edge; rdy_in low 3 cycles -> all state frozen.
REQ-037 With ALU_PIPE_MUL_EN, MULH a=0xFFFFFFFF b=0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; without macro, MUL -> 0.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined integer ALU with reorder-buffer tags, valid/ready handshakes, flush and global enable.
// Optional multiplier opcodes (16-19) are built only when ALU_PIPE_MUL_EN is defined.
module alu_pipe #(
    parameter int XLEN      = 32,
    parameter int ROB_WIDTH = 4,
    parameter int DEPTH     = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           alu_op,
    input  logic [XLEN-1:0]      a,
    input  logic [XLEN-1:0]      b,
    input  logic [ROB_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      result,
    output logic [ROB_WIDTH-1:0] out_tag
);

    localparam int SHW  = $clog2(XLEN);
    localparam int LAST = DEPTH - 1;
    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] FOUR = {{(XLEN-3){1'b0}}, 3'd4};

    function automatic logic [XLEN-1:0] zext_f(input logic bit_i);
        return {{(XLEN-1){1'b0}}, bit_i};
    endfunction

    function automatic logic [XLEN-1:0] alu_f(input logic [4:0] op,
                                              input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
        logic [XLEN-1:0] r;
        logic [SHW-1:0]  sh;
`ifdef ALU_PIPE_MUL_EN
        logic [2*XLEN-1:0] mx;
        logic [2*XLEN-1:0] my;
        logic [2*XLEN-1:0] prod;
        mx   = {(2*XLEN){1'b0}};
        my   = {(2*XLEN){1'b0}};
        prod = {(2*XLEN){1'b0}};
`endif
        sh = y[SHW-1:0];
        r  = ZERO;
        case (op)
            5'd0:  r = x + y;
            5'd1:  r = x - y;
            5'd2:  r = x & y;
            5'd3:  r = x | y;
            5'd4:  r = x ^ y;
            5'd5:  r = x << sh;
            5'd6:  r = x >> sh;
            5'd7:  r = $signed(x) >>> sh;
            5'd8:  r = zext_f($signed(x) < $signed(y));
            5'd9:  r = zext_f(x < y);
            5'd10: r = zext_f(x == y);
            5'd11: r = zext_f($signed(x) >= $signed(y));
            5'd12: r = zext_f(x >= y);
            5'd13: r = zext_f(x != y);
            5'd14: r = x + y - FOUR;
`ifdef ALU_PIPE_MUL_EN
            // One 2*XLEN multiply; operand extension selects signed/unsigned flavour.
            5'd16, 5'd17, 5'd18, 5'd19: begin
                mx   = (op == 5'd17 || op == 5'd18) ? {{XLEN{x[XLEN-1]}}, x} : {{XLEN{1'b0}}, x};
                my   = (op == 5'd17) ? {{XLEN{y[XLEN-1]}}, y} : {{XLEN{1'b0}}, y};
                prod = mx * my;
                r    = (op == 5'd16) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            end
`endif
            default: r = ZERO;
        endcase
        return r;
    endfunction

    logic [DEPTH-1:0]     vld_q;
    logic [DEPTH-1:0]     vld_d;
    logic [XLEN-1:0]      res_q [DEPTH];
    logic [ROB_WIDTH-1:0] tag_q [DEPTH];
    logic [DEPTH-1:0]     free_s;
    logic                 accept_s;
    logic [XLEN-1:0]      alu_res_s;

    // Stage k is free when empty or when everything downstream lets it move on.
    always_comb begin : free_chain
        logic down;
        logic cur;
        free_s = {DEPTH{1'b0}};
        down   = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            cur       = !vld_q[k] || down;
            free_s[k] = cur;
            down      = cur;
        end
        in_ready  = rst_in && rdy_in && !clear && free_s[0];
        accept_s  = in_ready && in_valid;
        alu_res_s = alu_f(alu_op, a, b);
    end

    // Next-state valid bits: freeze on !rdy_in, flush on clear, else shift.
    always_comb begin
        vld_d = vld_q;
        if (!rdy_in) begin
            vld_d = vld_q;
        end else if (clear) begin
            vld_d = {DEPTH{1'b0}};
        end else begin
            if (free_s[0]) begin
                vld_d[0] = accept_s;
            end else begin
                vld_d[0] = vld_q[0];
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (free_s[k]) begin
                    vld_d[k] = vld_q[k-1];
                end else begin
                    vld_d[k] = vld_q[k];
                end
            end
        end
    end

    // Stage registers; payload only moves when a valid op enters the stage.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_q <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                res_q[k] <= ZERO;
                tag_q[k] <= {ROB_WIDTH{1'b0}};
            end
        end else if (rdy_in) begin
            vld_q <= vld_d;
            if (!clear) begin
                if (accept_s) begin
                    res_q[0] <= alu_res_s;
                    tag_q[0] <= in_tag;
                end
                for (int k = 1; k < DEPTH; k++) begin
                    if (free_s[k] && vld_q[k-1]) begin
                        res_q[k] <= res_q[k-1];
                        tag_q[k] <= tag_q[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = vld_q[LAST];
    assign result    = res_q[LAST];
    assign out_tag   = tag_q[LAST];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (defaults XLEN=32, ROB_WIDTH=4, DEPTH=2); honours ALU_PIPE_MUL_EN.
module tb_alu_pipe;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  alu_op;
    logic [31:0] a, b, result;
    logic [3:0]  in_tag, out_tag;

    always #5 clk_in = ~clk_in;

    alu_pipe dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op), .a(a), .b(b),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag)
    );

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] res;
    } exp_t;

    exp_t sb_q[$];
    exp_t pend;
    int   n_vec = 0;
    int   n_err = 0;
    bit   rnd_ready = 1'b0;
    bit   last_acc;
    int   tries;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        int          sh;
        logic [63:0] p;
        sh = int'(y[4:0]);
        case (op)
            5'd0:  return x + y;
            5'd1:  return x - y;
            5'd2:  return x & y;
            5'd3:  return x | y;
            5'd4:  return x ^ y;
            5'd5:  return x << sh;
            5'd6:  return x >> sh;
            5'd7:  return 32'($signed(x) >>> sh);
            5'd8:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            5'd9:  return (x < y) ? 32'd1 : 32'd0;
            5'd10: return (x == y) ? 32'd1 : 32'd0;
            5'd11: return ($signed(x) >= $signed(y)) ? 32'd1 : 32'd0;
            5'd12: return (x >= y) ? 32'd1 : 32'd0;
            5'd13: return (x != y) ? 32'd1 : 32'd0;
            5'd14: return x + y - 32'd4;
`ifdef ALU_PIPE_MUL_EN
            5'd16: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
            5'd17: begin p = 64'(longint'($signed(x)) * longint'($signed(y))); return p[63:32]; end
            5'd18: begin p = 64'(longint'($signed(x)) * longint'({32'd0, y})); return p[63:32]; end
            5'd19: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
`endif
            default: return 32'd0;
        endcase
    endfunction

    // One clock: score handshakes seen before the edge, then advance.
    task automatic tick();
        exp_t e;
        #1;
        if (rnd_ready) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
        end
        last_acc = rst_in && rdy_in && !clear && in_valid && in_ready;
        if (rst_in && rdy_in && !clear && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("result", 64'(result), 64'(e.res));
                check_val("out_tag", 64'(out_tag), 64'(e.tag));
            end
        end
        if (rdy_in && clear) sb_q.delete();
        if (last_acc) sb_q.push_back(pend);
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] tag, input logic [31:0] exp, output int n);
        alu_op   = op;
        a        = x;
        b        = y;
        in_tag   = tag;
        pend     = {tag, exp};
        in_valid = 1'b1;
        n        = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) check_val("accept_timeout", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        check_val("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 5'd0; a = 32'd0; b = 32'd0; in_tag = 4'd0;
        #1 rst_in = 1'b0;
        #2;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_result", 64'(result), 64'd0);
        check_val("rst_out_tag", 64'(out_tag), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;

        // Basic latency: ADD 5+7 tag 3 appears exactly two edges after accept.
        issue(5'd0, 32'd5, 32'd7, 4'd3, 32'd12, tries);
        check_val("first_accept_tries", 64'(tries), 64'd1);
        check_val("lat_cycle1_valid", 64'(out_valid), 64'd0);
        tick();
        check_val("lat_cycle2_valid", 64'(out_valid), 64'd1);
        check_val("lat_result", 64'(result), 64'd12);
        check_val("lat_tag", 64'(out_tag), 64'd3);
        drain();

        // Back-to-back full throughput.
        issue(5'd7,  32'h8000_0000, 32'd4, 4'd1, 32'hF800_0000, tries);
        check_val("b2b_sra_tries", 64'(tries), 64'd1);
        issue(5'd8,  32'hFFFF_FFFF, 32'd1, 4'd2, 32'd1, tries);
        check_val("b2b_slt_tries", 64'(tries), 64'd1);
        issue(5'd9,  32'hFFFF_FFFF, 32'd1, 4'd3, 32'd0, tries);
        check_val("b2b_sltu_tries", 64'(tries), 64'd1);
        issue(5'd14, 32'h0000_0100, 32'd8, 4'd4, 32'h104, tries);
        check_val("b2b_addpc_tries", 64'(tries), 64'd1);
        drain();

        // Backpressure: two ops fill the pipe, the third waits, output holds.
        out_ready = 1'b0;
        issue(5'd0, 32'd1,    32'd2,    4'd1, 32'd3,    tries);
        issue(5'd4, 32'hF0,   32'hFF,   4'd2, 32'h0F,   tries);
        alu_op = 5'd1; a = 32'd10; b = 32'd3; in_tag = 4'd3; pend = {4'd3, 32'd7}; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("bp_in_ready", 64'(in_ready), 64'd0);
            check_val("bp_out_valid", 64'(out_valid), 64'd1);
            check_val("bp_hold_result", 64'(result), 64'd3);
            check_val("bp_hold_tag", 64'(out_tag), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        tries = 0;
        do begin
            tick();
            tries++;
        end while (!last_acc && tries < 20);
        check_val("bp_third_accepted", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
        drain();

        // Flush with two in flight plus a concurrent request.
        issue(5'd0, 32'd100, 32'd1, 4'hA, 32'd101, tries);
        issue(5'd0, 32'd200, 32'd1, 4'hB, 32'd201, tries);
        alu_op = 5'd0; a = 32'd300; b = 32'd1; in_tag = 4'hC; pend = {4'hC, 32'd301};
        in_valid = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check_val("clr_out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 6; i++) begin
            check_val("clr_no_flushed_tag", 64'(out_valid), 64'd0);
            tick();
        end

        // rdy_in low freezes everything, clear ignored.
        out_ready = 1'b0;
        issue(5'd2, 32'hFF00, 32'h0FF0, 4'd5, 32'h0F00, tries);
        issue(5'd3, 32'hFF00, 32'h0FF0, 4'd6, 32'hFFF0, tries);
        rdy_in = 1'b0; clear = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        pend = {4'd9, 32'd0};
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("frz_in_ready", 64'(in_ready), 64'd0);
            check_val("frz_out_valid", 64'(out_valid), 64'd1);
            check_val("frz_result", 64'(result), 64'h0F00);
            check_val("frz_tag", 64'(out_tag), 64'd5);
            tick();
        end
        rdy_in = 1'b1; clear = 1'b0; in_valid = 1'b0;
        drain();

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        issue(5'd0, 32'd1, 32'd1, 4'd7, 32'd2, tries);
        issue(5'd0, 32'd2, 32'd2, 4'd8, 32'd4, tries);
        #2 rst_in = 1'b0;
        #1;
        check_val("arst_out_valid", 64'(out_valid), 64'd0);
        check_val("arst_result", 64'(result), 64'd0);
        check_val("arst_out_tag", 64'(out_tag), 64'd0);
        check_val("arst_in_ready", 64'(in_ready), 64'd0);
        sb_q.delete();
        #1 rst_in = 1'b1;
        out_ready = 1'b1;
        issue(5'd1, 32'd9, 32'd4, 4'd2, 32'd5, tries);
        check_val("arst_first_accept", 64'(tries), 64'd1);
        drain();

        // Multiplier opcodes and undefined opcodes.
`ifdef ALU_PIPE_MUL_EN
        issue(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'd0,          tries);
        issue(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'hFFFF_FFFE, tries);
        issue(5'd16, 32'd3,         32'd4,         4'd3, 32'd12,         tries);
`else
        issue(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'd0, tries);
        issue(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'd0, tries);
        issue(5'd16, 32'd3,         32'd4,         4'd3, 32'd0, tries);
`endif
        issue(5'd15, 32'd3, 32'd4, 4'd4, 32'd0, tries);
        issue(5'd25, 32'd3, 32'd4, 4'd5, 32'd0, tries);
        drain();

        // Random traffic with random backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [4:0]  op;
            logic [31:0] x, y;
            op = 5'($urandom_range(0, 31));
            x  = $urandom();
            y  = $urandom();
            issue(op, x, y, 4'(i), model(op, x, y), tries);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
